transpose_buffer_pp: RTL and testbench

Parametrised, double-buffered (ping-pong) block transpose buffer for the 2-D block-transform datapath. It accepts N×N blocks of WIDTH-bit samples in raster order and emits each block either transposed (column-major) or unchanged (raster), selected per block. Two banks let one block fill while the previous block drains, so steady-state throughput is one sample per clock on both sides. It sits between the row-pass and column-pass stages.

---
 rtl/transpose_buffer_pp.sv | 134 +++++++++++++
 tb/tb_transpose_buffer_pp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_buffer_pp.sv
// rtl/transpose_buffer_pp.sv - ping-pong N x N block transpose buffer
// One bank fills in raster order while the other drains transposed or raster.
module transpose_buffer_pp #(
   parameter int WIDTH = 12,
   parameter int N     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] S_in,
   input  logic             ena_in,
   output logic             rdy_out,
   input  logic             mode_in,
   output logic [WIDTH-1:0] S_out,
   output logic             ena_out,
   input  logic             rdy_in
);

   localparam int L  = $clog2(N);
   localparam int AW = 2 * L;

   typedef enum logic [1:0] {
      B_EMPTY,
      B_FILLING,
      B_FULL,
      B_DRAINING
   } bank_state_t;

   bank_state_t      bank_q [2];
   bank_state_t      bank_d [2];
   logic [1:0]       mode_q;
   logic             wbank;
   logic             rbank;
   logic             rd_active;
   logic             out_bank;
   logic             out_last;
   logic [AW-1:0]    wcnt;
   logic [AW-1:0]    rcnt;
   logic [AW-1:0]    raddr;
   logic             wr_xfer;
   logic             issue;
   logic             out_xfer;
   logic             wcnt_last;
   logic             rcnt_last;
   logic [WIDTH-1:0] mem [2*N*N];

   assign rdy_out   = rst & ((bank_q[wbank] == B_EMPTY) || (bank_q[wbank] == B_FILLING));
   assign wr_xfer   = ena_in & rdy_out;
   assign out_xfer  = ena_out & rdy_in;
   // A read is issued only when the output register is free or being emptied this edge.
   assign issue     = rd_active & (~ena_out | rdy_in);
   assign wcnt_last = &wcnt;
   assign rcnt_last = &rcnt;
   // Transposed address swaps the row/column halves of the output index.
   assign raddr     = mode_q[rbank] ? {rcnt[L-1:0], rcnt[AW-1:L]} : rcnt;

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         bank_d[b] = bank_q[b];
         if (wr_xfer && (wbank == b[0])) begin
            if (wcnt_last)
               bank_d[b] = B_FULL;
            else if (wcnt == '0)
               bank_d[b] = B_FILLING;
         end
         if (issue && (rbank == b[0]) && (rcnt == '0))
            bank_d[b] = B_DRAINING;
         if (out_xfer && out_last && (out_bank == b[0]))
            bank_d[b] = B_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_q[0] <= B_EMPTY;
         bank_q[1] <= B_EMPTY;
      end else begin
         bank_q[0] <= bank_d[0];
         bank_q[1] <= bank_d[1];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_xfer)
         mem[{wbank, wcnt}] <= S_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt   <= '0;
         wbank  <= 1'b0;
         mode_q <= '0;
      end else if (wr_xfer) begin
         wcnt <= wcnt + AW'(1);
         if (wcnt == '0)
            mode_q[wbank] <= mode_in;
         if (wcnt_last)
            wbank <= ~wbank;
      end
   end

   // Chain straight into the other bank when it is already full, so back-to-back blocks have no bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rcnt      <= '0;
         rbank     <= 1'b0;
         rd_active <= 1'b0;
      end else if (issue) begin
         rcnt <= rcnt + AW'(1);
         if (rcnt_last) begin
            rbank     <= ~rbank;
            rd_active <= (bank_q[~rbank] == B_FULL);
         end
      end else if (!rd_active && (bank_q[rbank] == B_FULL)) begin
         rd_active <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         S_out    <= '0;
         ena_out  <= 1'b0;
         out_bank <= 1'b0;
         out_last <= 1'b0;
      end else if (issue) begin
         S_out    <= mem[{rbank, raddr}];
         ena_out  <= 1'b1;
         out_bank <= rbank;
         out_last <= rcnt_last;
      end else if (rdy_in) begin
         ena_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_transpose_buffer_pp.sv
// tb/tb_transpose_buffer_pp.sv - directed bench for transpose_buffer_pp
module tb_transpose_buffer_pp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] S_in = '0;
   logic        ena_in = 1'b0;
   logic        rdy_out;
   logic        mode_in = 1'b0;
   logic [11:0] S_out;
   logic        ena_out;
   logic        rdy_in = 1'b1;

   logic [15:0] S_in4 = '0;
   logic        ena_in4 = 1'b0;
   logic        rdy_out4;
   logic        mode_in4 = 1'b0;
   logic [15:0] S_out4;
   logic        ena_out4;
   logic        rdy_in4 = 1'b1;

   always #5 clk = ~clk;

   transpose_buffer_pp #(.WIDTH(12), .N(8)) dut (
      .clk(clk), .rst(rst),
      .S_in(S_in), .ena_in(ena_in), .rdy_out(rdy_out), .mode_in(mode_in),
      .S_out(S_out), .ena_out(ena_out), .rdy_in(rdy_in)
   );

   transpose_buffer_pp #(.WIDTH(16), .N(4)) dut4 (
      .clk(clk), .rst(rst),
      .S_in(S_in4), .ena_in(ena_in4), .rdy_out(rdy_out4), .mode_in(mode_in4),
      .S_out(S_out4), .ena_out(ena_out4), .rdy_in(rdy_in4)
   );

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int last_in_cyc = 0;
   int oq[$];
   int oc[$];
   int oq4[$];
   int exp_q[$];
   bit saw_full = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst && ena_out && rdy_in) begin
         oq.push_back(int'(S_out));
         oc.push_back(cyc);
      end
      if (rst && ena_out4 && rdy_in4)
         oq4.push_back(int'(S_out4));
      if (rst && !rdy_out)
         saw_full = 1'b1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic send(input int v, input bit m);
      int guard;
      bit ok;
      S_in    = v[11:0];
      mode_in = m;
      ena_in  = 1'b1;
      guard   = 0;
      ok      = 1'b0;
      do begin
         @(negedge clk);
         ok = rdy_out;
         @(posedge clk);
         #1;
         guard++;
      end while (!ok && guard < 1000);
      if (!ok)
         check("send_ready", int'(ok), 1);
      else
         last_in_cyc = cyc;
   endtask

   task automatic send_block(input int base, input bit m, input bit toggle);
      for (int i = 0; i < 64; i++)
         send(base + i, (toggle && i > 0) ? i[0] : m);
      ena_in = 1'b0;
   endtask

   task automatic expect_block(input int base, input bit tr);
      for (int j = 0; j < 64; j++)
         exp_q.push_back(tr ? base + (j % 8) * 8 + j / 8 : base + j);
   endtask

   task automatic wait_out(input int n);
      int g;
      g = 0;
      while (oq.size() < n && g < 3000) begin
         @(posedge clk);
         #1;
         g++;
      end
      repeat (10) @(posedge clk);
      #1;
      check("out_count", oq.size(), n);
   endtask

   task automatic compare(input string tag);
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_%0d", tag, i), (i < oq.size()) ? oq[i] : -1, exp_q[i]);
      oq.delete();
      oc.delete();
      exp_q.delete();
   endtask

   initial begin
      int k3;
      int g4;

      #2 rst = 1'b0;
      @(negedge clk);
      check("rst_rdy_out", int'(rdy_out), 0);
      check("rst_ena_out", int'(ena_out), 0);
      check("rst_S_out", int'(S_out), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("post_rst_rdy_out", int'(rdy_out), 1);
      check("post_rst_ena_out", int'(ena_out), 0);
      @(posedge clk);
      #1;

      // single transposed block, latency and contiguity
      expect_block(100, 1'b1);
      send_block(100, 1'b1, 1'b0);
      wait_out(64);
      if (oc.size() >= 64) begin
         check("t1_latency", oc[0] - last_in_cyc, 2);
         check("t1_span", oc[63] - oc[0], 63);
      end
      compare("t1");

      // three back-to-back blocks
      expect_block(100, 1'b1);
      expect_block(200, 1'b1);
      expect_block(300, 1'b1);
      send_block(100, 1'b1, 1'b0);
      send_block(200, 1'b1, 1'b0);
      send_block(300, 1'b1, 1'b0);
      k3 = last_in_cyc;
      wait_out(192);
      if (oc.size() >= 192) begin
         check("t2_span_b1b2", oc[127] - oc[0], 127);
         check("t2_b3_latency", oc[128] - k3, 2);
         check("t2_span_b3", oc[191] - oc[128], 63);
      end
      compare("t2");

      // mode switch with mode_in toggling inside the raster block
      expect_block(100, 1'b1);
      expect_block(200, 1'b0);
      send_block(100, 1'b1, 1'b0);
      send_block(200, 1'b0, 1'b1);
      wait_out(128);
      compare("t3");

      // backpressure while input keeps streaming
      saw_full = 1'b0;
      expect_block(100, 1'b1);
      expect_block(200, 1'b1);
      expect_block(300, 1'b1);
      fork
         begin
            send_block(100, 1'b1, 1'b0);
            send_block(200, 1'b1, 1'b0);
            send_block(300, 1'b1, 1'b0);
         end
         begin
            int gs;
            gs = 0;
            while (oq.size() < 10 && gs < 2000) begin
               @(posedge clk);
               #1;
               gs++;
            end
            rdy_in = 1'b0;
            for (int s = 0; s < 12; s++) begin
               @(negedge clk);
               check("stall_S_out", int'(S_out), 117);
               check("stall_ena_out", int'(ena_out), 1);
            end
            @(posedge clk);
            #1 rdy_in = 1'b1;
         end
      join
      wait_out(192);
      check("t4_rdy_out_dropped", int'(saw_full), 1);
      compare("t4");

      // reset in the middle of a block
      for (int i = 0; i < 30; i++)
         send(400 + i, 1'b1);
      ena_in = 1'b0;
      #3 rst = 1'b0;
      #1;
      check("mid_rst_ena_out", int'(ena_out), 0);
      check("mid_rst_S_out", int'(S_out), 0);
      check("mid_rst_rdy_out", int'(rdy_out), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      oq.delete();
      oc.delete();
      expect_block(500, 1'b1);
      send_block(500, 1'b1, 1'b0);
      wait_out(64);
      compare("t5");

      // N=4, WIDTH=16 instance
      check("n4_rdy_out", int'(rdy_out4), 1);
      for (int i = 0; i < 16; i++) begin
         S_in4    = 16'(32'h1000 + i);
         mode_in4 = 1'b1;
         ena_in4  = 1'b1;
         @(posedge clk);
         #1;
      end
      ena_in4 = 1'b0;
      g4 = 0;
      while (oq4.size() < 16 && g4 < 200) begin
         @(posedge clk);
         #1;
         g4++;
      end
      check("n4_count", oq4.size(), 16);
      for (int j = 0; j < 16; j++)
         check($sformatf("n4_%0d", j), (j < oq4.size()) ? oq4[j] : -1,
               32'h1000 + (j % 4) * 4 + j / 4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
